// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, access-size
// encodings and the alignment checks used to flag misaligned accesses.
// Sub-word helpers are only used when STAGE_MEM_SUBWORD_EN is defined.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;
    localparam logic [1:0] ACC_RSVD = 2'b11;   // behaves as a word access

    // Word-only build: any non-zero low address bit is misaligned.
    function automatic logic misalign_word(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

    // Sized build: bytes never misalign, halves need bit 0 clear, words need both clear.
    function automatic logic misalign_sized(input logic [1:0] acc_size,
                                            input logic [1:0] addr_lo);
        logic res;
        case (acc_size)
            ACC_BYTE: res = 1'b0;
            ACC_HALF: res = addr_lo[0];
            default:  res = (addr_lo != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Word-organised data memory with per-byte lane write enables.
// One synchronous write port, one asynchronous read port; contents are not reset.
module data_mem
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Lane-masked write; each enabled byte lane takes its slice of i_wdata.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stage_mem.sv
// Memory stage: accepts one EX operation at a time, performs the load/store
// against data_mem after WAIT_CYCLES extra cycles and emits a one-cycle
// write-back pulse. Define STAGE_MEM_SUBWORD_EN to enable byte/half accesses;
// without it every access is a word access.
module stage_mem
    import pipeline_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] outAlu,
    input  logic [31:0] storeData,
    input  logic [4:0]  writeReg,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic [1:0]  accSize,
    input  logic        loadUnsigned,
    output logic        wbValid,
    output logic [4:0]  wbReg,
    output logic        wbRegWrite,
    output logic [31:0] wbData,
    output logic        misalign
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);

    mem_state_e  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_reg;
    logic        r_load;
    logic        r_store;
    logic        r_regWrite;
    logic        r_memToReg;
    logic        r_misal;

    logic          w_misal_in;
    logic          w_commit;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_lane_data;
    logic [31:0]   w_rdata;
    logic [31:0]   w_load_data;
    logic [AW-1:0] w_idx;

`ifdef STAGE_MEM_SUBWORD_EN
    logic [1:0] r_size;
    logic       r_unsigned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_misal_in = misalign_sized(accSize, outAlu[1:0]);

    // Lane enables and replicated store data so the addressed lane sees the low bits.
    always_comb begin
        w_be        = 4'hF;
        w_lane_data = r_wdata;
        case (r_size)
            ACC_BYTE: begin
                w_be        = 4'b0001 << r_addr[1:0];
                w_lane_data = {4{r_wdata[7:0]}};
            end
            ACC_HALF: begin
                w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'hF;
                w_lane_data = r_wdata;
            end
        endcase
    end

    // Extract the addressed lane and sign/zero extend sub-word loads.
    always_comb begin
        w_byte      = w_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half      = r_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_load_data = w_rdata;
        case (r_size)
            ACC_BYTE: w_load_data = r_unsigned ? {24'h0, w_byte}
                                               : {{24{w_byte[7]}}, w_byte};
            ACC_HALF: w_load_data = r_unsigned ? {16'h0, w_half}
                                               : {{16{w_half[15]}}, w_half};
            default:  w_load_data = w_rdata;
        endcase
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{accSize, loadUnsigned};
    assign w_misal_in   = misalign_word(outAlu[1:0]);
    assign w_be         = 4'hF;
    assign w_lane_data  = r_wdata;
    assign w_load_data  = w_rdata;
`endif

    assign inReady  = (r_state == ST_IDLE);
    assign w_idx    = r_addr[AW+1:2];
    assign w_commit = (r_state == ST_ACCESS) && (r_cnt == 3'd0);
    assign w_we     = w_commit && r_store && !r_misal;

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (w_idx),
        .i_wdata (w_lane_data),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // Stage FSM: capture on transfer, count down the access, then pulse write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_reg      <= 5'd0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_regWrite <= 1'b0;
            r_memToReg <= 1'b0;
            r_misal    <= 1'b0;
`ifdef STAGE_MEM_SUBWORD_EN
            r_size     <= ACC_WORD;
            r_unsigned <= 1'b0;
`endif
            wbValid    <= 1'b0;
            wbReg      <= 5'd0;
            wbRegWrite <= 1'b0;
            wbData     <= 32'h0;
            misalign   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    wbValid  <= 1'b0;
                    misalign <= 1'b0;
                    if (inValid) begin
                        r_addr     <= outAlu;
                        r_wdata    <= storeData;
                        r_reg      <= writeReg;
                        r_store    <= memWrite;
                        r_load     <= memRead && !memWrite;   // store wins when both set
                        r_regWrite <= regWrite;
                        r_memToReg <= memToReg;
                        r_misal    <= w_misal_in;
`ifdef STAGE_MEM_SUBWORD_EN
                        r_size     <= accSize;
                        r_unsigned <= loadUnsigned;
`endif
                        if (memRead || memWrite) begin
                            r_state <= ST_ACCESS;
                            r_cnt   <= WAIT_CNT;
                        end else begin
                            r_state    <= ST_RESP;
                            wbValid    <= 1'b1;
                            wbReg      <= writeReg;
                            wbRegWrite <= regWrite;
                            wbData     <= outAlu;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 3'd0) begin
                        r_state    <= ST_RESP;
                        wbValid    <= 1'b1;
                        misalign   <= r_misal;
                        wbReg      <= r_reg;
                        wbRegWrite <= r_regWrite && !r_misal;
                        wbData     <= (r_load && r_memToReg) ? w_load_data : r_addr;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    wbValid  <= 1'b0;
                    misalign <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem. Two instances: u_dut1 (WAIT_CYCLES=1)
// carries the main scenarios, u_dut2 (WAIT_CYCLES=2) the mid-access reset.
// Expected write-back bundles come from a byte-addressed reference memory and
// are queued per instance, then popped when the instance pulses wbValid.
`timescale 1ns/1ps
module tb_stage_mem;

    typedef struct {
        logic [4:0]  rg;
        logic        rw;
        logic [31:0] data;
        logic        mis;
        int          xfer;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        v1, v2;
    logic        inReady1, inReady2;
    logic [31:0] outAlu, storeData;
    logic [4:0]  writeReg;
    logic        memRead, memWrite, regWrite, memToReg;
    logic [1:0]  accSize;
    logic        loadUnsigned;
    logic        wbValid1, wbRegWrite1, misalign1;
    logic [4:0]  wbReg1;
    logic [31:0] wbData1;
    logic        wbValid2, wbRegWrite2, misalign2;
    logic [4:0]  wbReg2;
    logic [31:0] wbData2;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t m_e1, m_e2;
    logic [7:0] mb [2][256];

    stage_mem #(.DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .inValid(v1), .inReady(inReady1),
        .outAlu(outAlu), .storeData(storeData), .writeReg(writeReg),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg),
        .accSize(accSize), .loadUnsigned(loadUnsigned),
        .wbValid(wbValid1), .wbReg(wbReg1), .wbRegWrite(wbRegWrite1),
        .wbData(wbData1), .misalign(misalign1)
    );

    stage_mem #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .inValid(v2), .inReady(inReady2),
        .outAlu(outAlu), .storeData(storeData), .writeReg(writeReg),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite), .memToReg(memToReg),
        .accSize(accSize), .loadUnsigned(loadUnsigned),
        .wbValid(wbValid2), .wbReg(wbReg2), .wbRegWrite(wbRegWrite2),
        .wbData(wbData2), .misalign(misalign2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one operation; updates the byte memory for stores.
    task automatic model(input int d, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wr, input logic mr, input logic mw,
                         input logic rw, input logic m2r, input logic [1:0] sz,
                         input logic uns, output exp_t e);
        int         nb;
        int         m;
        logic [7:0] ba;
        logic [31:0] v;
        m  = d - 1;
        ba = a[7:0];
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifndef STAGE_MEM_SUBWORD_EN
        nb = 4;
`endif
        e.rg   = wr;
        e.rw   = rw;
        e.data = a;
        e.mis  = 1'b0;
        e.xfer = 0;
        e.lat  = 1;
        if (mr || mw) begin
            e.mis = ((int'(ba[1:0]) % nb) != 0);
            e.rw  = rw && !e.mis;
            if (mw) begin
                if (!e.mis)
                    for (int i = 0; i < nb; i++) mb[m][ba + 8'(i)] = sd[8*i +: 8];
            end else begin
                v = 32'h0;
                if (e.mis) begin
                    for (int i = 0; i < 4; i++) v[8*i +: 8] = mb[m][{ba[7:2], 2'b00} + 8'(i)];
                end else begin
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[m][ba + 8'(i)];
                    if (nb == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
                    if (nb == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
                end
                if (m2r) e.data = v;
            end
        end
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wr, input logic mr, input logic mw,
                         input logic rw, input logic m2r, input logic [1:0] sz,
                         input logic uns);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (((d == 1) ? inReady1 : inReady2) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        outAlu = a; storeData = sd; writeReg = wr;
        memRead = mr; memWrite = mw; regWrite = rw; memToReg = m2r;
        accSize = sz; loadUnsigned = uns;
        if (d == 1) v1 = 1'b1; else v2 = 1'b1;
        model(d, a, sd, wr, mr, mw, rw, m2r, sz, uns, e);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v2 = 1'b0;
        check((d == 1) ? "busy_inready1" : "busy_inready2",
              (d == 1) ? inReady1 : inReady2, 32'd0);
        e.xfer = cyc;
        e.lat  = (mr || mw) ? ((d == 1) ? 3 : 4) : 1;
        if (d == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 1) ? q1.size() : q2.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("drain_timeout", 32'(n), 32'd0);
    endtask

    // Scoreboard pop for the WAIT_CYCLES=1 instance.
    always @(negedge clk) begin
        if (wbValid1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("wb1_spurious", 32'd1, 32'd0);
            end else begin
                m_e1 = q1.pop_front();
                check("wb1_reg", 32'(wbReg1), 32'(m_e1.rg));
                check("wb1_regwrite", 32'(wbRegWrite1), 32'(m_e1.rw));
                check("wb1_data", wbData1, m_e1.data);
                check("wb1_misalign", 32'(misalign1), 32'(m_e1.mis));
                check("wb1_latency", 32'(cyc - m_e1.xfer + 1), 32'(m_e1.lat));
            end
        end else if (misalign1 !== 1'b0) begin
            check("mis1_idle", 32'(misalign1), 32'd0);
        end
    end

    // Scoreboard pop for the WAIT_CYCLES=2 instance.
    always @(negedge clk) begin
        if (wbValid2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("wb2_spurious", 32'd1, 32'd0);
            end else begin
                m_e2 = q2.pop_front();
                check("wb2_reg", 32'(wbReg2), 32'(m_e2.rg));
                check("wb2_regwrite", 32'(wbRegWrite2), 32'(m_e2.rw));
                check("wb2_data", wbData2, m_e2.data);
                check("wb2_misalign", 32'(misalign2), 32'(m_e2.mis));
                check("wb2_latency", 32'(cyc - m_e2.xfer + 1), 32'(m_e2.lat));
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0;
        outAlu = 32'h0; storeData = 32'h0; writeReg = 5'd0;
        memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b0; memToReg = 1'b0;
        accSize = 2'b10; loadUnsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inready", 32'(inReady1), 32'd1);
        check("rst_wbvalid", 32'(wbValid1), 32'd0);
        check("rst_wbdata", wbData1, 32'd0);
        check("rst_wbreg", 32'(wbReg1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // word store / load
        issue(1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 2'b10, 0); drain(1);
        issue(1, 32'h10, 32'h0, 5'd3, 1, 0, 1, 1, 2'b10, 0);        drain(1);

        // passthrough
        issue(1, 32'h1234, 32'h0, 5'd7, 0, 0, 1, 0, 2'b10, 0);      drain(1);

        // misaligned word store leaves 0x20 untouched
        issue(1, 32'h20, 32'h11223344, 5'd0, 0, 1, 0, 0, 2'b10, 0); drain(1);
        issue(1, 32'h22, 32'hFFFF0000, 5'd4, 0, 1, 1, 0, 2'b10, 0); drain(1);
        issue(1, 32'h20, 32'h0, 5'd5, 1, 0, 1, 1, 2'b10, 0);        drain(1);

`ifdef STAGE_MEM_SUBWORD_EN
        // byte sign / zero extension
        issue(1, 32'h20, 32'h000080FF, 5'd0, 0, 1, 0, 0, 2'b10, 0); drain(1);
        issue(1, 32'h21, 32'h0, 5'd6, 1, 0, 1, 1, 2'b00, 0);        drain(1);
        issue(1, 32'h21, 32'h0, 5'd6, 1, 0, 1, 1, 2'b00, 1);        drain(1);
        issue(1, 32'h22, 32'h0000A5C3, 5'd0, 0, 1, 0, 0, 2'b01, 0); drain(1);
        issue(1, 32'h22, 32'h0, 5'd8, 1, 0, 1, 1, 2'b01, 0);        drain(1);
        issue(1, 32'h20, 32'h0, 5'd8, 1, 0, 1, 1, 2'b10, 0);        drain(1);
        issue(1, 32'h21, 32'h0, 5'd9, 0, 1, 1, 0, 2'b01, 0);        drain(1);
`endif

        // read+write together: store wins, data is the address
        issue(1, 32'h40, 32'h5A5A1234, 5'd10, 1, 1, 1, 1, 2'b10, 0); drain(1);
        issue(1, 32'h40, 32'h0, 5'd11, 1, 0, 1, 1, 2'b10, 0);        drain(1);

        // wrap-around
        issue(1, 32'h100, 32'hCAFEF00D, 5'd0, 0, 1, 0, 0, 2'b10, 0); drain(1);
        issue(1, 32'h000, 32'h0, 5'd12, 1, 0, 1, 1, 2'b10, 0);       drain(1);

        // random aligned word traffic with junk upper address bits
        for (int k = 0; k < 6; k++) begin
            ra = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
            rd = $urandom;
            issue(1, ra, rd, 5'd0, 0, 1, 0, 0, 2'b10, 0);   drain(1);
            issue(1, ra, 32'h0, 5'(k + 1), 1, 0, 1, 1, 2'b10, 0); drain(1);
        end

        // reset in the first ACCESS cycle of a store (WAIT_CYCLES=2 instance)
        issue(2, 32'h30, 32'hAAAA5555, 5'd0, 0, 1, 0, 0, 2'b10, 0); drain(2);
        @(negedge clk);
        outAlu = 32'h30; storeData = 32'h12345678; writeReg = 5'd2;
        memRead = 1'b0; memWrite = 1'b1; regWrite = 1'b1; memToReg = 1'b0;
        accSize = 2'b10; loadUnsigned = 1'b0;
        v2 = 1'b1;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        check("abort_busy", 32'(inReady2), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_inready", 32'(inReady2), 32'd1);
        check("abort_wbvalid", 32'(wbValid2), 32'd0);
        check("abort_wbdata", wbData2, 32'd0);
        check("abort_wbreg", 32'(wbReg2), 32'd0);
        check("abort_regwrite", 32'(wbRegWrite2), 32'd0);
        check("abort_misalign", 32'(misalign2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(2, 32'h30, 32'h0, 5'd13, 1, 0, 1, 1, 2'b10, 0); drain(2);

        // dut1 memory must survive the reset
        issue(1, 32'h10, 32'h0, 5'd14, 1, 0, 1, 1, 2'b10, 0); drain(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
